// File: rtl/ex_flush_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ex_flush_ctrl_pkg
// Shared definitions for the write-back exception/ERTN sequencer:
//   - ws_ex_vec bit positions ({int, adef, ine, brk, sys, ale, ertn})
//   - LoongArch exception codes for each exception source
//   - sequencer FSM state encoding
// ----------------------------------------------------------------------------
package ex_flush_ctrl_pkg;

    localparam int EX_NUM = 7;

    // Bit positions inside ws_ex_vec; bit 6 is the highest priority.
    localparam int IDX_INT  = 6;
    localparam int IDX_ADEF = 5;
    localparam int IDX_INE  = 4;
    localparam int IDX_BRK  = 3;
    localparam int IDX_SYS  = 2;
    localparam int IDX_ALE  = 1;
    localparam int IDX_ERTN = 0;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } state_e;

endpackage

// File: rtl/ex_flush_ctrl_prio_enc.sv
// ----------------------------------------------------------------------------
// ex_prio_enc
// Combinational fixed-priority encoder for the WB exception flag vector.
// Ports:
//   i_ex_vec    in  7  {int, adef, ine, brk, sys, ale, ertn}
//   o_is_ex     out 1  at least one exception bit set
//   o_is_ertn   out 1  ertn bit set and no exception bit set
//   o_ecode     out 6  exception code of the winning source (0 for ERTN/none)
//   o_vaddr_we  out 1  winning source writes BADV (adef or ale)
//   o_sel       out 7  one-hot select of the winning bit, same order as i_ex_vec
// ----------------------------------------------------------------------------
module ex_prio_enc
    import ex_flush_ctrl_pkg::*;
(
    input  logic [6:0] i_ex_vec,
    output logic       o_is_ex,
    output logic       o_is_ertn,
    output logic [5:0] o_ecode,
    output logic       o_vaddr_we,
    output logic [6:0] o_sel
);

    // NOTE: every output gets a default before the priority chain so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        o_is_ex    = 1'b0;
        o_is_ertn  = 1'b0;
        o_ecode    = 6'h00;
        o_vaddr_we = 1'b0;
        o_sel      = 7'b0;
        if (i_ex_vec[IDX_INT]) begin
            o_is_ex         = 1'b1;
            o_ecode         = ECODE_INT;
            o_sel[IDX_INT]  = 1'b1;
        end else if (i_ex_vec[IDX_ADEF]) begin
            o_is_ex         = 1'b1;
            o_ecode         = ECODE_ADEF;
            o_vaddr_we      = 1'b1;
            o_sel[IDX_ADEF] = 1'b1;
        end else if (i_ex_vec[IDX_INE]) begin
            o_is_ex         = 1'b1;
            o_ecode         = ECODE_INE;
            o_sel[IDX_INE]  = 1'b1;
        end else if (i_ex_vec[IDX_BRK]) begin
            o_is_ex         = 1'b1;
            o_ecode         = ECODE_BRK;
            o_sel[IDX_BRK]  = 1'b1;
        end else if (i_ex_vec[IDX_SYS]) begin
            o_is_ex         = 1'b1;
            o_ecode         = ECODE_SYS;
            o_sel[IDX_SYS]  = 1'b1;
        end else if (i_ex_vec[IDX_ALE]) begin
            o_is_ex         = 1'b1;
            o_ecode         = ECODE_ALE;
            o_vaddr_we      = 1'b1;
            o_sel[IDX_ALE]  = 1'b1;
        end else if (i_ex_vec[IDX_ERTN]) begin
            o_is_ertn       = 1'b1;
            o_sel[IDX_ERTN] = 1'b1;
        end
    end

endmodule

// File: rtl/ex_flush_ctrl.sv
// ----------------------------------------------------------------------------
// ex_flush_ctrl
// Exception/ERTN sequencer for the LoongArch write-back stage. Picks one event
// per cycle from ws_ex_vec by fixed priority, emits the CSR commit signals in
// the event cycle, holds flush_all for FLUSH_CYCLES more cycles, then holds a
// redirect to IF (target EENTRY or ERA latched at the event edge) until taken.
//
// Optional build macro: EX_CNT_EN adds per-source saturating event counters
// (input cnt_clr, output ex_cnt[7*CNT_W-1:0], bit order as ws_ex_vec).
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   ws_valid, ws_ex_vec    WB instruction valid and its exception flags
//   ws_pc, ws_vaddr        WB PC and faulting address
//   csr_eentry, csr_era    current EENTRY / ERA
//   wb_ex, ertn_flush      one-cycle commit pulses to the CSR file
//   wb_ecode, wb_esubcode  exception code / subcode (subcode always 0)
//   wb_pc, wb_vaddr(_we)   ERA and BADV write data / BADV enable
//   flush_all              flush IF/ID/EX/MEM
//   commit_block           WB suppresses RF write and advance
//   redir_valid/pc/ready   redirect handshake with IF
//   busy                   sequencer not idle
// ----------------------------------------------------------------------------
module ex_flush_ctrl
    import ex_flush_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    input  logic [6:0]  ws_ex_vec,
    input  logic [31:0] ws_pc,
    input  logic [31:0] ws_vaddr,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        wb_vaddr_we,
    output logic        flush_all,
    output logic        commit_block,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    output logic        busy
`ifdef EX_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [7*CNT_W-1:0]   ex_cnt
`endif
);

    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_target;

    logic        w_is_ex;
    logic        w_is_ertn;
    logic [5:0]  w_ecode;
    logic        w_vaddr_we;
    logic [6:0]  w_sel;
    logic        w_event;

    ex_prio_enc u_prio_enc (
        .i_ex_vec   (ws_ex_vec),
        .o_is_ex    (w_is_ex),
        .o_is_ertn  (w_is_ertn),
        .o_ecode    (w_ecode),
        .o_vaddr_we (w_vaddr_we),
        .o_sel      (w_sel)
    );

    // resetn gates the event so the commit outputs drop the moment reset
    // asserts, not only after the state register has cleared.
    assign w_event = resetn && (r_state == ST_IDLE) && ws_valid && (ws_ex_vec != 7'b0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the combinational block below uses blocking ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Target is captured at the event edge, i.e. before the CSR file applies
    // the same-cycle ERA/ESTAT update, and held untouched until the next event.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= 4'd0;
            r_target <= 32'h0;
        end else if (w_event) begin
            r_cnt    <= FLUSH_LOAD;
            r_target <= w_is_ex ? csr_eentry : csr_era;
        end else if (r_state == ST_FLUSH && r_cnt != 4'd0) begin
            r_cnt    <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        wb_ex        = 1'b0;
        ertn_flush   = 1'b0;
        wb_ecode     = 6'h00;
        wb_esubcode  = 9'h000;
        wb_pc        = 32'h0;
        wb_vaddr     = 32'h0;
        wb_vaddr_we  = 1'b0;
        flush_all    = 1'b0;
        commit_block = 1'b0;
        redir_valid  = 1'b0;
        redir_pc     = 32'h0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    flush_all    = 1'b1;
                    commit_block = 1'b1;
                    if (w_is_ex) begin
                        wb_ex       = 1'b1;
                        wb_ecode    = w_ecode;
                        wb_pc       = ws_pc;
                        wb_vaddr    = ws_vaddr;
                        wb_vaddr_we = w_vaddr_we;
                    end else begin
                        ertn_flush  = w_is_ertn;
                    end
                    w_state_nxt = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_REDIR;
                end
            end
            ST_FLUSH: begin
                flush_all    = 1'b1;
                commit_block = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_REDIR;
                end
            end
            ST_REDIR: begin
                redir_valid  = 1'b1;
                redir_pc     = r_target;
                commit_block = 1'b1;
                if (redir_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);

`ifdef EX_CNT_EN
    for (genvar g = 0; g < EX_NUM; g++) begin : g_cnt
        logic [CNT_W-1:0] r_ev_cnt;

        // Clear wins over increment; counters stick at all-ones.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_ev_cnt <= '0;
            end else if (cnt_clr) begin
                r_ev_cnt <= '0;
            end else if (w_event && w_sel[g] && r_ev_cnt != '1) begin
                r_ev_cnt <= r_ev_cnt + 1'b1;
            end
        end

        assign ex_cnt[g*CNT_W +: CNT_W] = r_ev_cnt;
    end
`else
    logic w_unused_sel;
    assign w_unused_sel = ^w_sel;
`endif

endmodule

// File: tb/tb_ex_flush_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_flush_ctrl
// Self-checking bench for ex_flush_ctrl: directed cases plus randomized events
// compared against a priority-table reference model. Counter checks are built
// only when EX_CNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_ex_flush_ctrl;

    localparam int FC = 2;
    localparam int CW = 16;

    logic        clk;
    logic        resetn;
    logic        ws_valid;
    logic [6:0]  ws_ex_vec;
    logic [31:0] ws_pc;
    logic [31:0] ws_vaddr;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        wb_ex;
    logic        ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        wb_vaddr_we;
    logic        flush_all;
    logic        commit_block;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        busy;
`ifdef EX_CNT_EN
    logic              cnt_clr;
    logic [7*CW-1:0]   ex_cnt;
`endif

    ex_flush_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ws_valid     (ws_valid),
        .ws_ex_vec    (ws_ex_vec),
        .ws_pc        (ws_pc),
        .ws_vaddr     (ws_vaddr),
        .csr_eentry   (csr_eentry),
        .csr_era      (csr_era),
        .wb_ex        (wb_ex),
        .ertn_flush   (ertn_flush),
        .wb_ecode     (wb_ecode),
        .wb_esubcode  (wb_esubcode),
        .wb_pc        (wb_pc),
        .wb_vaddr     (wb_vaddr),
        .wb_vaddr_we  (wb_vaddr_we),
        .flush_all    (flush_all),
        .commit_block (commit_block),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .redir_ready  (redir_ready),
        .busy         (busy)
`ifdef EX_CNT_EN
        ,
        .cnt_clr      (cnt_clr),
        .ex_cnt       (ex_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: sources in priority order with their exception codes.
    localparam int PRI_IDX  [6] = '{6, 5, 4, 3, 2, 1};
    localparam int PRI_CODE [6] = '{'h0, 'h8, 'hD, 'hC, 'hB, 'h9};

    // Returns the ws_ex_vec bit position that wins; 0 means ERTN.
    function automatic int pick(input logic [6:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[PRI_IDX[i]]) return PRI_IDX[i];
        end
        return 0;
    endfunction

    function automatic int code_of(input int idx);
        for (int i = 0; i < 6; i++) begin
            if (PRI_IDX[i] == idx) return PRI_CODE[i];
        end
        return 0;
    endfunction

    longint cnt_exp [7];

    task automatic clear_model();
        for (int i = 0; i < 7; i++) cnt_exp[i] = 0;
    endtask

    // One IDLE cycle with no event: everything must read 0.
    task automatic idle_cycle();
        @(negedge clk);
        ws_valid    = 1'b0;
        ws_ex_vec   = 7'($urandom);
        redir_ready = 1'($urandom);
        #1;
        check("idle_busy", {63'b0, busy}, 64'd0);
        check("idle_ctl", {58'b0, wb_ex, ertn_flush, flush_all, commit_block, redir_valid, wb_vaddr_we}, 64'd0);
        check("idle_redir_pc", {32'b0, redir_pc}, 64'd0);
        check("idle_ecode", {58'b0, wb_ecode}, 64'd0);
    endtask

    // Full event: event cycle, FC flush cycles, REDIR with 'stall' not-ready cycles.
    task automatic run_event(input logic [6:0] vec, input logic [31:0] pc, input logic [31:0] va,
                             input logic [31:0] eentry, input logic [31:0] era, input int stall);
        int          idx;
        logic        is_ex;
        logic [31:0] target;
        idx    = pick(vec);
        is_ex  = (vec[6:1] != 6'b0);
        target = is_ex ? eentry : era;

        @(negedge clk);
        ws_valid    = 1'b1;
        ws_ex_vec   = vec;
        ws_pc       = pc;
        ws_vaddr    = va;
        csr_eentry  = eentry;
        csr_era     = era;
        redir_ready = 1'b1;
        #1;
        check("ev_busy", {63'b0, busy}, 64'd0);
        check("ev_wb_ex", {63'b0, wb_ex}, {63'b0, is_ex});
        check("ev_ertn_flush", {63'b0, ertn_flush}, {63'b0, !is_ex});
        check("ev_ecode", {58'b0, wb_ecode}, is_ex ? 64'(code_of(idx)) : 64'd0);
        check("ev_esubcode", {55'b0, wb_esubcode}, 64'd0);
        check("ev_vaddr_we", {63'b0, wb_vaddr_we}, {63'b0, is_ex && (idx == 5 || idx == 1)});
        check("ev_flush", {62'b0, flush_all, commit_block}, 64'd3);
        check("ev_redir_valid", {63'b0, redir_valid}, 64'd0);
        if (is_ex) begin
            check("ev_wb_pc", {32'b0, wb_pc}, {32'b0, pc});
            check("ev_wb_vaddr", {32'b0, wb_vaddr}, {32'b0, va});
        end
        if (cnt_exp[idx] < ((64'd1 << CW) - 1)) cnt_exp[idx]++;

        // CSR values change after the event edge; the latched target must not follow.
        for (int k = 0; k < FC; k++) begin
            @(negedge clk);
            ws_valid    = 1'($urandom);
            ws_ex_vec   = 7'($urandom) | 7'b0000100;
            csr_eentry  = $urandom;
            csr_era     = $urandom;
            redir_ready = 1'($urandom);
            #1;
            check("fl_flush", {62'b0, flush_all, commit_block}, 64'd3);
            check("fl_pulses", {62'b0, wb_ex, ertn_flush}, 64'd0);
            check("fl_redir_valid", {63'b0, redir_valid}, 64'd0);
            check("fl_busy", {63'b0, busy}, 64'd1);
        end

        // A sys flag stays present throughout REDIR and must be ignored.
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            ws_valid    = 1'b1;
            ws_ex_vec   = 7'b0000100;
            csr_eentry  = $urandom;
            csr_era     = $urandom;
            redir_ready = (s == stall);
            #1;
            check("rd_valid", {63'b0, redir_valid}, 64'd1);
            check("rd_pc", {32'b0, redir_pc}, {32'b0, target});
            check("rd_flush", {62'b0, flush_all, commit_block}, 64'd1);
            check("rd_wb_ex", {63'b0, wb_ex}, 64'd0);
            check("rd_busy", {63'b0, busy}, 64'd1);
        end
    endtask

`ifdef EX_CNT_EN
    task automatic check_counts(input string tag);
        for (int i = 0; i < 7; i++) begin
            check(tag, 64'(ex_cnt[i*CW +: CW]), 64'(cnt_exp[i]));
        end
    endtask
`endif

    initial begin
        resetn      = 1'b0;
        ws_valid    = 1'b0;
        ws_ex_vec   = 7'b0;
        ws_pc       = 32'h0;
        ws_vaddr    = 32'h0;
        csr_eentry  = 32'h0;
        csr_era     = 32'h0;
        redir_ready = 1'b0;
`ifdef EX_CNT_EN
        cnt_clr     = 1'b0;
`endif
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_redir_valid", {63'b0, redir_valid}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle_cycle();

        // ale only, FC=2, immediate accept.
        run_event(7'b0000010, 32'h1c000100, 32'h00000003, 32'h1c008000, 32'h11111111, 0);
        idle_cycle();
        // int + ale + ertn: int wins, no BADV, no ertn_flush.
        run_event(7'b1000011, 32'h1c000200, 32'h0000abcd, 32'h1c008000, 32'h22222222, 0);
        idle_cycle();
        // ertn only: redirect to ERA.
        run_event(7'b0000001, 32'h1c000300, 32'h0, 32'h1c008000, 32'h1c000204, 0);
        idle_cycle();
        // 5 stalled cycles in REDIR.
        run_event(7'b0001000, 32'h1c000400, 32'h0, 32'h1c00c000, 32'h0, 5);
        idle_cycle();

        // Reset asserted in FLUSH while an event is still presented.
        @(negedge clk);
        ws_valid  = 1'b1;
        ws_ex_vec = 7'b0100000;
        @(negedge clk);
        #1;
        check("prerst_flush", {63'b0, flush_all}, 64'd1);
        resetn = 1'b0;
        #1;
        check("asyncrst_ctl", {58'b0, wb_ex, ertn_flush, flush_all, commit_block, redir_valid, wb_vaddr_we}, 64'd0);
        check("asyncrst_busy", {63'b0, busy}, 64'd0);
        check("asyncrst_redir_pc", {32'b0, redir_pc}, 64'd0);
        @(negedge clk);
        ws_valid = 1'b0;
        resetn   = 1'b1;
        #1;
        check("postrst_busy", {63'b0, busy}, 64'd0);
        clear_model();
        idle_cycle();

`ifdef EX_CNT_EN
        // 3 sys then 1 brk.
        for (int i = 0; i < 3; i++) run_event(7'b0000100, 32'h1c000500, 32'h0, 32'h1c008000, 32'h0, 0);
        run_event(7'b0001000, 32'h1c000600, 32'h0, 32'h1c008000, 32'h0, 0);
        idle_cycle();
        check("cnt_sys3", 64'(ex_cnt[2*CW +: CW]), 64'd3);
        check("cnt_brk1", 64'(ex_cnt[3*CW +: CW]), 64'd1);
`endif

        // Randomized events with random stalls and idle gaps.
        for (int n = 0; n < 30; n++) begin
            logic [6:0] v;
            v = 7'($urandom_range(1, 127));
            run_event(v, $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
            repeat ($urandom_range(1, 2)) idle_cycle();
        end

`ifdef EX_CNT_EN
        check_counts("cnt_model");
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        clear_model();
        #1;
        check_counts("cnt_clr");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
